// File: rtl/axi4_sw_pkg.sv
// Shared definitions for the AXI4-stream switch family: default field widths,
// the stored beat layout and the packet FIFO write-FSM states.
package axi4_sw_pkg;

    localparam int TDATA_L_DEF = 512;
    localparam int TUSER_L_DEF = 81;
    localparam int TKEEP_L_DEF = 16;

    // Beat layout at default widths; the FIFO packs beats in this same field order.
    typedef struct packed {
        logic [TDATA_L_DEF-1:0] tdata;
        logic [TUSER_L_DEF-1:0] tuser;
        logic [TKEEP_L_DEF-1:0] tkeep;
        logic                   tlast;
    } axi_beat_t;

    typedef enum logic {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    function automatic int beat_width(input int data_l, input int user_l, input int keep_l);
        return data_l + user_l + keep_l + 1;
    endfunction

endpackage

// File: rtl/axi4_pkt_fifo_mem.sv
// Beat storage for the packet FIFO: one synchronous write port and one
// asynchronous read port so the egress beat is visible as soon as rd_ptr moves.
module axi4_pkt_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi4_pkt_fifo.sv
// Store-and-forward packet FIFO: a packet is released to egress only after its
// tlast beat is stored; packets longer than DEPTH beats are discarded whole.
module axi4_pkt_fifo
    import axi4_sw_pkg::*;
#(
    parameter int TDATA_L   = TDATA_L_DEF,
    parameter int TUSER_L   = TUSER_L_DEF,
    parameter int TKEEP_L   = TKEEP_L_DEF,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 4,
    localparam int OW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TDATA_L-1:0] axi_s_tdata_i,
    input  logic [TUSER_L-1:0] axi_s_tuser_i,
    input  logic [TKEEP_L-1:0] axi_s_tkeep_i,
    input  logic               axi_s_tlast_i,
    input  logic               axi_s_tvalid_i,
    output logic               axi_s_tready_o,
    output logic [TDATA_L-1:0] axi_m_tdata_o,
    output logic [TUSER_L-1:0] axi_m_tuser_o,
    output logic [TKEEP_L-1:0] axi_m_tkeep_o,
    output logic               axi_m_tlast_o,
    output logic               axi_m_tvalid_o,
    input  logic               axi_m_tready_i,
    output logic               almost_full_o,
    output logic               drop_o,
    output logic [OW-1:0]      occupancy_o,
    output logic               wr_state_o
);

    // Handshakes on both sides are plain AXI-stream: a beat moves on a rising
    // edge where valid and ready are both high; valid never waits on ready.

    localparam int AW = $clog2(DEPTH);
    localparam int BW = beat_width(TDATA_L, TUSER_L, TKEEP_L);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] AF_LIM   = OW'(AF_THRESH);
    localparam logic [AW-1:0] LEN_MAX  = AW'(DEPTH - 1);

    wr_state_t     wr_state, wr_state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, pkt_start, cur_len;
    logic [OW-1:0] occ, pkt_cnt, occ_sub, free_cnt;
    logic          s_ready, s_fire, wr_en, store, commit, drop;
    logic          m_valid, m_fire, rd_last;
    logic [BW-1:0] wr_beat, rd_beat;

    // Write FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_PASS;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // Write FSM: next state
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_PASS: if (drop) wr_state_nxt = WR_DROP;
            WR_DROP: if (s_fire && axi_s_tlast_i) wr_state_nxt = WR_PASS;
            default: wr_state_nxt = WR_PASS;
        endcase
    end

    // Write FSM: outputs. Drop mode swallows beats unconditionally so the
    // oversize tail never stalls the switch.
    always_comb begin
        s_ready = 1'b0;
        wr_en   = 1'b0;
        case (wr_state)
            WR_PASS: begin
                s_ready = !rst && (occ < OCC_FULL);
                wr_en   = s_ready && axi_s_tvalid_i;
            end
            WR_DROP: s_ready = !rst;
            default: s_ready = 1'b0;
        endcase
    end

    assign s_fire  = s_ready && axi_s_tvalid_i;
    assign commit  = wr_en && axi_s_tlast_i;
    assign drop    = wr_en && !axi_s_tlast_i && (cur_len == LEN_MAX);
    assign store   = wr_en && !drop;
    assign occ_sub = drop ? OW'(cur_len) : '0;

    assign m_valid = !rst && (pkt_cnt != '0);
    assign m_fire  = m_valid && axi_m_tready_i;
    assign rd_last = m_fire && rd_beat[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_start <= '0;
            cur_len   <= '0;
            occ       <= '0;
            pkt_cnt   <= '0;
            drop_o    <= 1'b0;
        end else begin
            if (wr_en) begin
                // An oversize packet rewinds to its first beat, releasing its space.
                wr_ptr <= drop ? pkt_start : wr_ptr + AW'(1);
                if (commit) begin
                    cur_len   <= '0;
                    pkt_start <= wr_ptr + AW'(1);
                end else if (drop) begin
                    cur_len <= '0;
                end else begin
                    cur_len <= cur_len + AW'(1);
                end
            end
            if (m_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            pkt_cnt <= pkt_cnt + OW'(commit) - OW'(rd_last);
            occ     <= occ + OW'(store) - OW'(m_fire) - occ_sub;
            drop_o  <= drop;
        end
    end

    assign wr_beat = {axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i, axi_s_tlast_i};

    axi4_pkt_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr),
        .rd_data (rd_beat)
    );

    assign {axi_m_tdata_o, axi_m_tuser_o, axi_m_tkeep_o, axi_m_tlast_o} = rd_beat;

    assign free_cnt       = OCC_FULL - occ;
    assign axi_s_tready_o = s_ready;
    assign axi_m_tvalid_o = m_valid;
    assign almost_full_o  = !rst && (free_cnt < AF_LIM);
    assign occupancy_o    = rst ? '0 : occ;
    assign wr_state_o     = wr_state;

endmodule

// File: tb/tb_axi4_pkt_fifo.sv
// Directed bench for axi4_pkt_fifo at DEPTH=8, AF_THRESH=2 with narrow fields;
// egress beats are checked in order against an expected queue.
module tb_axi4_pkt_fifo;

    localparam int DW    = 16;
    localparam int UW    = 4;
    localparam int KW    = 2;
    localparam int DEPTH = 8;
    localparam int AF    = 2;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic          almost_full, drop;
    logic [OW-1:0] occupancy;
    logic          wr_state;

    axi4_pkt_fifo #(
        .TDATA_L (DW), .TUSER_L (UW), .TKEEP_L (KW),
        .DEPTH (DEPTH), .AF_THRESH (AF)
    ) dut (
        .clk (clk), .rst (rst),
        .axi_s_tdata_i (s_tdata), .axi_s_tuser_i (s_tuser), .axi_s_tkeep_i (s_tkeep),
        .axi_s_tlast_i (s_tlast), .axi_s_tvalid_i (s_tvalid), .axi_s_tready_o (s_tready),
        .axi_m_tdata_o (m_tdata), .axi_m_tuser_o (m_tuser), .axi_m_tkeep_o (m_tkeep),
        .axi_m_tlast_o (m_tlast), .axi_m_tvalid_o (m_tvalid), .axi_m_tready_i (m_tready),
        .almost_full_o (almost_full), .drop_o (drop), .occupancy_o (occupancy),
        .wr_state_o (wr_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected beat image {tkeep, tuser, tlast, tdata}; drivers derive tuser/tkeep from tdata.
    function automatic logic [22:0] beat_img(input logic [15:0] d, input logic last);
        return {d[1:0], d[3:0] ^ 4'hF, last, d};
    endfunction

    // Scoreboard: every egress handshake pops one expected beat.
    logic [22:0] exp_q[$];
    int drop_cnt   = 0;
    bit valid_seen = 1'b0;
    int last_hs    = -1;
    int prev_hs    = -1;

    always @(negedge clk) begin
        logic [22:0] e;
        if (!rst) begin
            if (drop) drop_cnt++;
            if (m_tvalid) valid_seen = 1'b1;
            if (m_tvalid && m_tready) begin
                prev_hs = last_hs;
                last_hs = cyc;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 23'h7FFFFF;
                check("egress_beat", {9'b0, m_tkeep, m_tuser, m_tlast, m_tdata}, {9'b0, e});
            end
        end
    end

    // Driver tasks
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last, output int acc_cyc);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = d[3:0] ^ 4'hF;
        s_tkeep  = d[1:0];
        s_tlast  = last;
        acc_cyc  = -1;
        while (acc_cyc < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (s_tready) acc_cyc = cyc;
        end
        if (acc_cyc < 0) check("ingress_tready", 32'(s_tready), 32'd1);
        sync();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] base, input int len, input bit keep);
        int c;
        for (int i = 0; i < len; i++) begin
            if (keep) exp_q.push_back(beat_img(base + 16'(i), i == len - 1));
            send_beat(base + 16'(i), i == len - 1, c);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cb, drops0;
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; s_tuser = '0; s_tkeep = '0; m_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("post_rst_occ", 32'(occupancy), 32'd0);
        check("post_rst_tready", 32'(s_tready), 32'd1);
        check("post_rst_state", 32'(wr_state), 32'd0);
        sync();

        // Single beat: visible the cycle after its tlast is accepted
        exp_q.push_back(beat_img(16'h00A5, 1'b1));
        send_beat(16'h00A5, 1'b1, c);
        @(negedge clk);
        check("t1_valid", 32'(m_tvalid), 32'd1);
        check("t1_data", 32'(m_tdata), 32'h00A5);
        check("t1_last", 32'(m_tlast), 32'd1);
        sync();
        wait_drain("t1_drain");
        @(negedge clk);
        check("t1_occ", 32'(occupancy), 32'd0);
        sync();

        // Store-and-forward with gaps between ingress beats
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(beat_img(16'h0011 + 16'(i), i == 2));
            send_beat(16'h0011 + 16'(i), i == 2, c);
            if (i < 2) begin
                repeat (2) begin
                    @(negedge clk);
                    check("t2_hold_valid", 32'(m_tvalid), 32'd0);
                    sync();
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_contig_valid", 32'(m_tvalid), 32'd1);
        end
        @(negedge clk);
        check("t2_valid_after", 32'(m_tvalid), 32'd0);
        sync();
        wait_drain("t2_drain");

        // Backpressure: fill to DEPTH with egress stalled
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(beat_img(16'h0030 + 16'(k), (k % 4) == 3));
            send_beat(16'h0030 + 16'(k), (k % 4) == 3, c);
            @(negedge clk);
            check("t3_occ", 32'(occupancy), 32'(k + 1));
            check("t3_af", 32'(almost_full), 32'(k + 1 >= 7));
            sync();
        end
        @(negedge clk);
        check("t3_full_tready", 32'(s_tready), 32'd0);
        check("t3_full_valid", 32'(m_tvalid), 32'd1);
        sync();
        m_tready = 1'b1;
        @(negedge clk);
        check("t3_tready_before_read", 32'(s_tready), 32'd0);
        @(negedge clk);
        check("t3_tready_after_read", 32'(s_tready), 32'd1);
        sync();
        wait_drain("t3_drain");

        // Oversize packet is dropped whole; next packet survives
        drops0     = drop_cnt;
        valid_seen = 1'b0;
        send_pkt(16'h0040, 10, 1'b0);
        repeat (2) sync();
        @(negedge clk);
        check("t4_drop_pulses", 32'(drop_cnt - drops0), 32'd1);
        check("t4_occ", 32'(occupancy), 32'd0);
        check("t4_no_valid", 32'(valid_seen), 32'd0);
        check("t4_state", 32'(wr_state), 32'd0);
        sync();
        send_pkt(16'h005A, 1, 1'b1);
        wait_drain("t4_drain");

        // Back-to-back: B commits on the edge A's tlast drains
        exp_q.push_back(beat_img(16'h0061, 1'b0));
        exp_q.push_back(beat_img(16'h0062, 1'b1));
        exp_q.push_back(beat_img(16'h006B, 1'b1));
        send_beat(16'h0061, 1'b0, c);
        send_beat(16'h0062, 1'b1, c);
        sync();
        send_beat(16'h006B, 1'b1, cb);
        wait_drain("t5_drain");
        check("t5_same_edge", 32'(cb), 32'(prev_hs));
        check("t5_no_bubble", 32'(last_hs - prev_hs), 32'd1);

        // Reset mid-packet discards everything without a drop pulse
        drops0 = drop_cnt;
        send_beat(16'h0081, 1'b0, c);
        send_beat(16'h0082, 1'b0, c);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_occ", 32'(occupancy), 32'd0);
        check("t6_rst_valid", 32'(m_tvalid), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("t6_occ", 32'(occupancy), 32'd0);
        check("t6_valid", 32'(m_tvalid), 32'd0);
        check("t6_drop", 32'(drop), 32'd0);
        check("t6_no_drop_pulse", 32'(drop_cnt - drops0), 32'd0);
        sync();
        send_pkt(16'h0091, 2, 1'b1);
        wait_drain("t6_drain");
        @(negedge clk);
        check("final_occ", 32'(occupancy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
